// File: rtl/mem_access.sv
// Memory stage: issues req/ack data-memory transactions for loads and stores,
// aligns and extends load data, and produces next PC with a one-cycle done pulse.
module mem_access #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        is_branch,
    input  logic [31:0] branch_target,
    input  logic [31:0] pc,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        addr_fault,
    output logic        bus_err,
    output logic [31:0] next_pc
);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } state_t;

    localparam logic [15:0] TimeoutLim = 16'(TIMEOUT);

    state_t      state;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic        is_load_q;
    logic [31:0] npc_q;
    logic [15:0] wait_cnt;

    logic        mem_op;
    logic        width_ok;
    logic        misalign;
    logic        fault;
    logic [3:0]  be;
    logic [31:0] wdata_rep;
    logic [31:0] npc;

    // Decode of the live EX inputs; only consumed on the start edge in IDLE.
    always_comb begin
        mem_op = mem_read | mem_write;
        case (funct3)
            3'b000, 3'b001, 3'b010: width_ok = 1'b1;
            3'b100, 3'b101:         width_ok = ~mem_write;
            default:                width_ok = 1'b0;
        endcase
        misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        fault = mem_op & ((mem_read & mem_write) | ~width_ok | misalign);

        case (funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << addr[1:0];
                wdata_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                be        = 4'b0011 << addr[1:0];
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata;
            end
        endcase

        npc = is_branch ? branch_target : pc + 32'd4;
    end

    logic [31:0] shifted;
    logic [31:0] load_ext;
    logic [31:0] load_val;

    // Lane extraction from the returned word using the captured offset and width.
    always_comb begin
        shifted = bus_rdata >> {lane_q, 3'b000};
        case (funct3_q)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {24'd0, shifted[7:0]};
            3'b101:  load_ext = {16'd0, shifted[15:0]};
            default: load_ext = shifted;
        endcase
        load_val = is_load_q ? load_ext : 32'd0;
    end

    assign busy = (state != StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            funct3_q   <= 3'd0;
            lane_q     <= 2'd0;
            is_load_q  <= 1'b0;
            npc_q      <= 32'd0;
            wait_cnt   <= 16'd0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 32'd0;
            bus_wdata  <= 32'd0;
            bus_be     <= 4'd0;
            done       <= 1'b0;
            rdata      <= 32'd0;
            addr_fault <= 1'b0;
            bus_err    <= 1'b0;
            next_pc    <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        funct3_q  <= funct3;
                        lane_q    <= addr[1:0];
                        is_load_q <= mem_read;
                        npc_q     <= npc;
                        wait_cnt  <= 16'd0;
                        if (mem_op && !fault) begin
                            state     <= StAccess;
                            bus_req   <= 1'b1;
                            bus_we    <= mem_write;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_wdata <= wdata_rep;
                            bus_be    <= be;
                        end else begin
                            state      <= StDone;
                            done       <= 1'b1;
                            addr_fault <= fault;
                            bus_err    <= 1'b0;
                            rdata      <= 32'd0;
                            next_pc    <= npc;
                        end
                    end
                end
                StAccess: begin
                    wait_cnt <= wait_cnt + 16'd1;
                    // Ack beats a timeout landing on the same edge.
                    if (bus_ack) begin
                        state      <= StDone;
                        bus_req    <= 1'b0;
                        done       <= 1'b1;
                        addr_fault <= 1'b0;
                        bus_err    <= 1'b0;
                        rdata      <= load_val;
                        next_pc    <= npc_q;
                    end else if (wait_cnt == TimeoutLim - 16'd1) begin
                        state      <= StDone;
                        bus_req    <= 1'b0;
                        done       <= 1'b1;
                        addr_fault <= 1'b0;
                        bus_err    <= 1'b1;
                        rdata      <= 32'd0;
                        next_pc    <= npc_q;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access (TIMEOUT=4).
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        is_branch = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic [31:0] pc = 32'd0;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        addr_fault;
    logic        bus_err;
    logic [31:0] next_pc;

    int n_checks = 0;
    int n_fail = 0;

    mem_access #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .wdata(wdata), .is_branch(is_branch),
        .branch_target(branch_target), .pc(pc), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata), .busy(busy), .done(done), .rdata(rdata),
        .addr_fault(addr_fault), .bus_err(bus_err), .next_pc(next_pc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one EX result for a single start edge; returns 1 ns after that edge.
    task automatic issue(input logic mr, input logic mw, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic br,
                         input logic [31:0] tgt, input logic [31:0] p);
        mem_read = mr; mem_write = mw; funct3 = f3; addr = a; wdata = wd;
        is_branch = br; branch_target = tgt; pc = p; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
        n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", bus_req); end
        n_checks++; if (bus_be !== 4'd0) begin n_fail++; $display("FAIL reset_be got %b exp 0", bus_be); end
        n_checks++; if (bus_addr !== 32'd0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", bus_addr); end
        n_checks++; if (next_pc !== 32'd0) begin n_fail++; $display("FAIL reset_npc got %h exp 0", next_pc); end
        n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", rdata); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_loads();
        logic [31:0] la [6] = '{32'h103, 32'h101, 32'h102, 32'h102, 32'h108, 32'h100};
        logic [2:0]  lf [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
        logic [31:0] lr [6] = '{32'h80FFFFFF, 32'h00009A00, 32'h80010000, 32'h80010000,
                                32'hDEADBEEF, 32'h0000007F};
        logic [31:0] le [6] = '{32'hFFFFFF80, 32'h0000009A, 32'hFFFF8001, 32'h00008001,
                                32'hDEADBEEF, 32'h0000007F};
        logic [3:0]  lb [6] = '{4'b1000, 4'b0010, 4'b1100, 4'b1100, 4'b1111, 4'b0001};
        logic [31:0] lba [6] = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h108, 32'h100};
        for (int i = 0; i < 6; i++) begin
            issue(1'b1, 1'b0, lf[i], la[i], 32'h0, 1'b0, 32'h0, 32'h200 + 32'(i * 4));
            n_checks++; if (bus_req !== 1'b1 || bus_we !== 1'b0 || done !== 1'b0) begin
                n_fail++; $display("FAIL ld%0d_req got req=%b we=%b done=%b exp 1 0 0", i, bus_req, bus_we, done); end
            n_checks++; if (bus_be !== lb[i]) begin n_fail++; $display("FAIL ld%0d_be got %b exp %b", i, bus_be, lb[i]); end
            n_checks++; if (bus_addr !== lba[i]) begin n_fail++; $display("FAIL ld%0d_addr got %h exp %h", i, bus_addr, lba[i]); end
            bus_ack = 1'b1; bus_rdata = lr[i];
            step();
            bus_ack = 1'b0; bus_rdata = 32'h0;
            n_checks++; if (done !== 1'b1 || bus_req !== 1'b0 || bus_err !== 1'b0 || addr_fault !== 1'b0) begin
                n_fail++; $display("FAIL ld%0d_done got done=%b req=%b err=%b flt=%b exp 1 0 0 0", i, done, bus_req, bus_err, addr_fault); end
            n_checks++; if (rdata !== le[i]) begin n_fail++; $display("FAIL ld%0d_rdata got %h exp %h", i, rdata, le[i]); end
            n_checks++; if (next_pc !== 32'h204 + 32'(i * 4)) begin
                n_fail++; $display("FAIL ld%0d_npc got %h exp %h", i, next_pc, 32'h204 + 32'(i * 4)); end
            step();
            n_checks++; if (done !== 1'b0 || busy !== 1'b0 || rdata !== le[i]) begin
                n_fail++; $display("FAIL ld%0d_after got done=%b busy=%b rdata=%h exp 0 0 %h", i, done, busy, rdata, le[i]); end
        end
    endtask

    task automatic test_stores();
        // SH with two wait cycles; later input changes must not disturb the held bus.
        issue(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 1'b0, 32'h0, 32'h300);
        addr = 32'hFFF0; wdata = 32'h0; funct3 = 3'b010;
        for (int w = 0; w < 3; w++) begin
            n_checks++; if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h100 ||
                            bus_be !== 4'b1100 || bus_wdata !== 32'hABCDABCD) begin
                n_fail++; $display("FAIL sh_bus%0d got req=%b we=%b a=%h be=%b wd=%h exp 1 1 100 1100 abcdabcd",
                                   w, bus_req, bus_we, bus_addr, bus_be, bus_wdata); end
            if (w == 2) bus_ack = 1'b1;
            step();
        end
        bus_ack = 1'b0;
        n_checks++; if (done !== 1'b1 || rdata !== 32'h0 || next_pc !== 32'h304) begin
            n_fail++; $display("FAIL sh_done got done=%b rdata=%h npc=%h exp 1 0 304", done, rdata, next_pc); end
        step();
        issue(1'b0, 1'b1, 3'b000, 32'h101, 32'h777777CD, 1'b0, 32'h0, 32'h400);
        n_checks++; if (bus_be !== 4'b0010 || bus_wdata !== 32'hCDCDCDCD) begin
            n_fail++; $display("FAIL sb_bus got be=%b wd=%h exp 0010 cdcdcdcd", bus_be, bus_wdata); end
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        step();
    endtask

    task automatic test_faults();
        logic       fr [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic       fw [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [2:0] ff [4] = '{3'b010, 3'b000, 3'b100, 3'b011};
        logic [31:0] fa [4] = '{32'h1001, 32'h100, 32'h100, 32'h100};
        for (int i = 0; i < 4; i++) begin
            issue(fr[i], fw[i], ff[i], fa[i], 32'h0, 1'b0, 32'h0, 32'h500);
            n_checks++; if (done !== 1'b1 || addr_fault !== 1'b1 || bus_req !== 1'b0 || rdata !== 32'h0) begin
                n_fail++; $display("FAIL flt%0d got done=%b flt=%b req=%b rdata=%h exp 1 1 0 0", i, done, addr_fault, bus_req, rdata); end
            step();
            n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL flt%0d_after got done=%b busy=%b exp 0 0", i, done, busy); end
        end
    endtask

    task automatic test_timeout();
        issue(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 1'b0, 32'h0, 32'h600);
        for (int c = 0; c < 4; c++) begin
            n_checks++; if (bus_req !== 1'b1 || done !== 1'b0) begin
                n_fail++; $display("FAIL to_wait%0d got req=%b done=%b exp 1 0", c, bus_req, done); end
            step();
        end
        n_checks++; if (done !== 1'b1 || bus_err !== 1'b1 || bus_req !== 1'b0 || rdata !== 32'h0) begin
            n_fail++; $display("FAIL to_err got done=%b err=%b req=%b rdata=%h exp 1 1 0 0", done, bus_err, bus_req, rdata); end
        step();
        // Ack on the fourth request cycle coincides with the timeout edge.
        issue(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 1'b0, 32'h0, 32'h600);
        step(); step(); step();
        bus_ack = 1'b1; bus_rdata = 32'h11223344;
        step();
        bus_ack = 1'b0;
        n_checks++; if (done !== 1'b1 || bus_err !== 1'b0 || rdata !== 32'h11223344) begin
            n_fail++; $display("FAIL to_ack got done=%b err=%b rdata=%h exp 1 0 11223344", done, bus_err, rdata); end
        step();
    endtask

    task automatic test_rst_mid();
        issue(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 1'b0, 32'h0, 32'h700);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (bus_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid got req=%b busy=%b done=%b exp 0 0 0", bus_req, busy, done); end
        bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
        for (int c = 0; c < 2; c++) begin
            step();
            n_checks++; if (done !== 1'b0 || busy !== 1'b0 || rdata !== 32'h0) begin
                n_fail++; $display("FAIL rst_late_ack%0d got done=%b busy=%b rdata=%h exp 0 0 0", c, done, busy, rdata); end
        end
        bus_ack = 1'b0;
    endtask

    task automatic test_nonmem();
        issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 32'h10, 32'h40);
        n_checks++; if (done !== 1'b1 || next_pc !== 32'h10 || bus_req !== 1'b0 || addr_fault !== 1'b0) begin
            n_fail++; $display("FAIL nm_branch got done=%b npc=%h req=%b flt=%b exp 1 10 0 0", done, next_pc, bus_req, addr_fault); end
        step();
        issue(1'b0, 1'b0, 3'b111, 32'h0, 32'h0, 1'b0, 32'h10, 32'hFFFFFFFC);
        n_checks++; if (done !== 1'b1 || next_pc !== 32'h0 || addr_fault !== 1'b0) begin
            n_fail++; $display("FAIL nm_wrap got done=%b npc=%h flt=%b exp 1 0 0", done, next_pc, addr_fault); end
        step();
        n_checks++; if (done !== 1'b0 || next_pc !== 32'h0) begin
            n_fail++; $display("FAIL nm_hold got done=%b npc=%h exp 0 0", done, next_pc); end
    endtask

    task automatic test_back_to_back();
        issue(1'b0, 1'b1, 3'b010, 32'h800, 32'h55AA55AA, 1'b0, 32'h0, 32'h900);
        // A second start while busy must be dropped.
        issue(1'b1, 1'b0, 3'b000, 32'h444, 32'h0, 1'b1, 32'h20, 32'h0);
        n_checks++; if (bus_addr !== 32'h800 || bus_we !== 1'b1 || bus_req !== 1'b1) begin
            n_fail++; $display("FAIL b2b_bus got a=%h we=%b req=%b exp 800 1 1", bus_addr, bus_we, bus_req); end
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        n_checks++; if (done !== 1'b1 || next_pc !== 32'h904) begin
            n_fail++; $display("FAIL b2b_done got done=%b npc=%h exp 1 904", done, next_pc); end
        step(); step();
        n_checks++; if (done !== 1'b0 || busy !== 1'b0 || bus_req !== 1'b0) begin
            n_fail++; $display("FAIL b2b_noqueue got done=%b busy=%b req=%b exp 0 0 0", done, busy, bus_req); end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_faults();
        test_timeout();
        test_rst_mid();
        test_nonmem();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
